// File: rtl/pipeline_ctrl.sv
// ---------------------------------------------------------------------------
// pipeline_ctrl
//   Stall/flush scheduler for the 5-stage core. It arbitrates four events
//   (data-memory wait, halt request, taken-branch redirect and load-use
//   hazard) into the PC enable plus the pipeline-register enables and clears.
//   It also keeps saturating stall and flush counters for performance debug.
//
// Ports
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   rs1_de, rs2_de        source registers of the instruction in DE
//   rd_ex, DMRd_ex        destination register of the EX instruction; EX is a load
//   br_taken_ex           EX redirects the PC (taken branch/jump)
//   dmem_req_me           MEM stage is accessing data memory
//   dmem_ready            data memory completes the access this cycle
//   halt_req, resume      enter HALT (from EX) / leave HALT (1-cycle pulse)
//   pc_en, fd_en, de_en,
//   em_en                 register enables (em_en covers EX/ME and ME/WB)
//   fd_clr, de_clr        synchronous bubble insertion into FE/DE and DE/EX
//   halted                controller sits in HALT
//   mem_err               sticky data-memory timeout flag
//   stall_cnt, flush_cnt  saturating cycle/event counters
// ---------------------------------------------------------------------------
module pipeline_ctrl #(
    parameter int MEM_TIMEOUT = 16,   // expected to be >= 2
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       rs1_de,
    input  logic [4:0]       rs2_de,
    input  logic [4:0]       rd_ex,
    input  logic             DMRd_ex,
    input  logic             br_taken_ex,
    input  logic             dmem_req_me,
    input  logic             dmem_ready,
    input  logic             halt_req,
    input  logic             resume,
    output logic             pc_en,
    output logic             fd_en,
    output logic             de_en,
    output logic             em_en,
    output logic             fd_clr,
    output logic             de_clr,
    output logic             halted,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int                WC_W    = $clog2(MEM_TIMEOUT + 1);
    // wait_cnt already counts the cycle spent entering MEM_WAIT, so the
    // last permitted wait cycle is the one holding MEM_TIMEOUT-1.
    localparam logic [WC_W-1:0]   TO_LAST = WC_W'(MEM_TIMEOUT - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX = '1;

    typedef enum logic [1:0] {S_RUN, S_MEM_WAIT, S_HALT} state_t;

    typedef struct packed {
        logic pc;
        logic fd;
        logic de;
        logic em;
        logic fd_clr;
        logic de_clr;
    } ctl_t;

    state_t           r_state, w_state_nxt;
    logic [WC_W-1:0]  r_wait_cnt, w_wait_nxt;
    logic             r_mem_err, w_mem_err_nxt;
    logic [CNT_W-1:0] r_stall_cnt, r_flush_cnt;

    ctl_t             w_ctl;
    logic             w_halted;
    logic             w_hazard;
    logic             w_freeze;
    logic             w_resolve;   // evaluate halt/branch/hazard priority list
    logic             w_flush;     // taken branch accepted this cycle

    // x0 is hardwired, so a load targeting it never creates a dependency.
    assign w_hazard = DMRd_ex && (rd_ex != 5'd0) &&
                      ((rs1_de == rd_ex) || (rs2_de == rd_ex));
    assign w_freeze = dmem_req_me && !dmem_ready;

    always_comb begin
        w_ctl         = '0;
        w_halted      = 1'b0;
        w_state_nxt   = r_state;
        w_wait_nxt    = r_wait_cnt;
        w_mem_err_nxt = r_mem_err;
        w_flush       = 1'b0;
        w_resolve     = 1'b0;

        case (r_state)
            S_RUN: begin
                if (w_freeze) begin
                    w_state_nxt = S_MEM_WAIT;
                    w_wait_nxt  = WC_W'(1);
                end else begin
                    w_resolve = 1'b1;
                end
            end
            S_MEM_WAIT: begin
                if (!dmem_ready) begin
                    w_wait_nxt = r_wait_cnt + 1'b1;
                    if (r_wait_cnt == TO_LAST) begin
                        w_state_nxt   = S_HALT;
                        w_wait_nxt    = '0;
                        w_mem_err_nxt = 1'b1;
                    end
                end else begin
                    // Registers held during the wait, so the events that
                    // were masked are re-judged now that memory is done.
                    w_resolve = 1'b1;
                end
            end
            S_HALT: begin
                w_halted = 1'b1;
                if (resume)
                    w_state_nxt = S_RUN;
            end
            default: w_state_nxt = S_RUN;
        endcase

        if (w_resolve) begin
            w_state_nxt = S_RUN;
            w_wait_nxt  = '0;
            if (halt_req) begin
                w_state_nxt = S_HALT;
            end else if (br_taken_ex) begin
                // DE instruction is squashed, so any hazard is irrelevant.
                w_ctl   = '1;
                w_flush = 1'b1;
            end else if (w_hazard) begin
                // Hold PC and FE/DE, push one bubble into EX.
                w_ctl.de     = 1'b1;
                w_ctl.em     = 1'b1;
                w_ctl.de_clr = 1'b1;
            end else begin
                w_ctl.pc = 1'b1;
                w_ctl.fd = 1'b1;
                w_ctl.de = 1'b1;
                w_ctl.em = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_RUN;
            r_wait_cnt  <= '0;
            r_mem_err   <= 1'b0;
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_wait_cnt <= w_wait_nxt;
            r_mem_err  <= w_mem_err_nxt;
            if (!w_ctl.pc && (r_stall_cnt != CNT_MAX))
                r_stall_cnt <= r_stall_cnt + 1'b1;
            if (w_flush && (r_flush_cnt != CNT_MAX))
                r_flush_cnt <= r_flush_cnt + 1'b1;
        end
    end

    // Reset forces the outputs immediately, independent of the clock.
    assign pc_en     = rst_n && w_ctl.pc;
    assign fd_en     = rst_n && w_ctl.fd;
    assign de_en     = rst_n && w_ctl.de;
    assign em_en     = rst_n && w_ctl.em;
    assign fd_clr    = !rst_n || w_ctl.fd_clr;
    assign de_clr    = !rst_n || w_ctl.de_clr;
    assign halted    = rst_n && w_halted;
    assign mem_err   = r_mem_err;
    assign stall_cnt = r_stall_cnt;
    assign flush_cnt = r_flush_cnt;

endmodule
